// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared encodings and parameter bounds for the fetch-stage sequencing controller.
package pc_ctrl_pkg;
   typedef enum logic {RUN, LDSTALL} state_t;
   localparam logic [1:0] PCSEL_SEQ = 2'd0;
   localparam logic [1:0] PCSEL_BR  = 2'd1;
   localparam logic [1:0] PCSEL_J   = 2'd2;
   localparam logic [1:0] PCSEL_JR  = 2'd3;
   localparam int LSC_MIN = 1;
   localparam int LSC_MAX = 4;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator between the EX load and the ID sources.
module load_use_detect (
   input  logic       mem_read,
   input  logic [4:0] idex_rt,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic       uses_rs,
   input  logic       uses_rt,
   output logic       hz
);
   assign hz = mem_read && idex_rt != 5'd0 &&
               ((uses_rs && idex_rt == ifid_rs) || (uses_rt && idex_rt == ifid_rt));
endmodule

// File: rtl/pc_control_unit.sv
// pc_control_unit: PC/IF-ID/ID-EX sequencing for the 5-stage pipeline with fixed redirect/stall priority.
// Optional PC_CTRL_PERF_EN adds stall_cycles and flush_count performance counters.
module pc_control_unit
   import pc_ctrl_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rt,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic       ifid_uses_rs,
   input  logic       ifid_uses_rt,
   input  logic       jump,
   input  logic       jr,
   input  logic       branch_taken,
   input  logic       imem_ready,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic       ifid_write,
   output logic       ifid_flush,
   output logic       idex_flush
`ifdef PC_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);
   localparam int LSC = LOAD_STALL_CYCLES < LSC_MIN ? LSC_MIN :
                        LOAD_STALL_CYCLES > LSC_MAX ? LSC_MAX : LOAD_STALL_CYCLES;

   state_t     state, state_n;
   logic [1:0] cnt, cnt_n;
   logic       hz;

   // jr always reads rs, so it counts as an rs user even if decode forgot to flag it
   load_use_detect u_detect (
      .mem_read (idex_mem_read),
      .idex_rt  (idex_rt),
      .ifid_rs  (ifid_rs),
      .ifid_rt  (ifid_rt),
      .uses_rs  (ifid_uses_rs | jr),
      .uses_rt  (ifid_uses_rt),
      .hz       (hz)
   );

   always_comb begin
      pc_write   = 1'b1;
      pc_sel     = PCSEL_SEQ;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      state_n    = state;
      cnt_n      = cnt;
      if (rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_n    = RUN;
         cnt_n      = 2'd0;
      end else if (branch_taken) begin
         pc_sel     = PCSEL_BR;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_n    = RUN;
         cnt_n      = 2'd0;
      end else if (state == LDSTALL || hz) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
         if (state == LDSTALL) begin
            state_n = cnt == 2'd1 ? RUN : LDSTALL;
            cnt_n   = cnt - 2'd1;
         end else if (LSC > 1) begin
            state_n = LDSTALL;
            cnt_n   = 2'(LSC - 1);
         end
      end else if (jr || jump) begin
         pc_sel     = jr ? PCSEL_JR : PCSEL_J;
         ifid_flush = 1'b1;
      end else if (!imem_ready) begin
         pc_write   = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

`ifdef PC_CTRL_PERF_EN
   // outside reset, pc_write low means stall or fetch wait; flush with pc_write high means a redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         stall_cycles <= stall_cycles + {31'd0, !pc_write};
         flush_count  <= flush_count + {31'd0, pc_write && ifid_flush};
      end
   end
`endif
endmodule

// File: doc/pc_control_unit.md
# pc_control_unit

Sequencing controller for the fetch stage of the 5-stage MIPS pipeline. It drives the program counter's write enable and next-PC mux select, and the IF/ID and ID/EX write and flush controls. It resolves load-use stalls, jumps, register jumps and taken branches with a fixed priority. It sits beside the hazard/forwarding logic and is the only source of `pc_write` in the processor.

## Interface
- `LOAD_STALL_CYCLES`, default 1: stall cycles inserted per load-use hazard, legal range 1..4. Use 2 for builds without MEM→EX forwarding.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `idex_mem_read`  in  1  instruction in EX is a load.
- `idex_rt`  in  5  destination register of the EX load.
- `ifid_rs`, `ifid_rt`  in  5 each  source registers of the instruction in ID.
- `ifid_uses_rs`, `ifid_uses_rt`  in  1 each  ID instruction actually reads that field.
- `jump`  in  1  `j`/`jal` decoded in ID.
- `jr`  in  1  `jr` decoded in ID.
- `branch_taken`  in  1  branch resolved taken in EX.
- `imem_ready`  in  1  instruction memory returned the word at the current PC.
- `pc_write`  out  1  PC register load enable.
- `pc_sel`  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = `jr` register value.
- `ifid_write`  out  1  IF/ID register enable.
- `ifid_flush`  out  1  load a NOP into IF/ID.
- `idex_flush`  out  1  load a bubble into ID/EX.

## Operation
- FSM states:
  - RUN: normal operation.
  - LDSTALL: extended load-use stall.
  - The state register and a 2-bit remaining-stall counter `cnt` are the only state, apart from the performance counters.
- Hazard detection (`hz`) is true when `idex_mem_read` is 1 and either:
  - `ifid_uses_rs` is 1, `idex_rt == ifid_rs`, and `idex_rt != 0`; or
  - `ifid_uses_rt` is 1, `idex_rt == ifid_rt`, and `idex_rt != 0`.
  - `jr` asserts `ifid_uses_rs`.
- Priority per cycle, highest first. All outputs are Mealy combinational from state and inputs.
  1. `branch_taken`:
     - Outputs: `pc_write=1`, `pc_sel=1`, `ifid_write=1`, `ifid_flush=1`, `idex_flush=1`.
     - Next state RUN; `cnt` cleared. This aborts any stall, because the stalled instruction is wrong-path.
  2. Stall, when in LDSTALL or when `hz` is true in RUN:
     - Outputs: `pc_write=0`, `ifid_write=0`, `idex_flush=1`, `pc_sel=0`.
     - `hz` in RUN with `LOAD_STALL_CYCLES>1`: next state LDSTALL, `cnt = LOAD_STALL_CYCLES-1`.
     - In LDSTALL: if `cnt==1`, next state RUN; otherwise `cnt` decrements.
     - `hz` is ignored while in LDSTALL.
  3. `jr` or `jump` in ID with no stall:
     - Outputs: `pc_write=1`, `pc_sel=3` (`jr`) or 2 (`jump`), `ifid_flush=1`, `ifid_write=1`.
     - `jr` wins if both `jr` and `jump` are set.
  4. `!imem_ready`:
     - Outputs: `pc_write=0`, `ifid_write=1`, `ifid_flush=1`; a bubble enters ID.
  5. Default:
     - Outputs: `pc_write=1`, `pc_sel=0`, `ifid_write=1`, both flushes 0.
- Redirects (priorities 1 and 3) are issued regardless of `imem_ready`. The instruction memory discards the pending fetch.

## Timing
- Reset (`rst=1` at a clock edge):
  - State becomes RUN, `cnt=0`, performance counters become 0.
  - While `rst` is high, outputs are forced to `pc_write=0`, `pc_sel=0`, `ifid_write=0`, `ifid_flush=1`, `idex_flush=1`.
  - Reset asserted mid-stall aborts the stall immediately.
- Redirect latency: the target is loaded into the PC at the edge ending the cycle in which `branch_taken`, `jump` or `jr` is seen.
  - Branch penalty: 2 squashed instructions.
  - Jump penalty: 1 squashed instruction.
- Load-use: exactly `LOAD_STALL_CYCLES` cycles have `pc_write=0`, starting with the detection cycle.
- The whole block has zero-cycle input-to-output latency; state updates on `posedge clk` only.

## Configuration
- `PC_CTRL_PERF_EN`: when defined, adds two outputs:
  - `stall_cycles` [31:0]: counts cycles with priority 2 or 4 active.
  - `flush_count` [31:0]: counts priority-1 and priority-3 events.
  - Both wrap modulo 2^32 and are cleared by `rst`.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `pc_ctrl_pkg` holds:
  - `pc_sel` encodings: `PCSEL_SEQ`, `PCSEL_BR`, `PCSEL_J`, `PCSEL_JR`.
  - The FSM state encoding.
  - The `LOAD_STALL_CYCLES` legal bounds.
- Sub-module `load_use_detect`: purely combinational `hz` comparator, reused by the forwarding-unit tests.

## Test plan
- Load-use, default parameter:
  - Stimulus: `idex_mem_read=1`, `idex_rt=8`, `ifid_rs=8`, `ifid_uses_rs=1`.
  - Required: `pc_write=0`, `ifid_write=0`, `idex_flush=1` for 1 cycle, then `pc_write=1`.
- Load-use with `LOAD_STALL_CYCLES=3`:
  - Required: 3 consecutive stall cycles.
  - Also: `branch_taken` in the 2nd cycle yields `pc_sel=1`, `pc_write=1`, and RUN on the next cycle.
- `idex_rt=0` with a matching `ifid_rt=0` → no stall; `pc_write=1`, `pc_sel=0`.
- `jr=1` and `jump=1` together → `pc_sel=3`, `ifid_flush=1`, `idex_flush=0`.
- `imem_ready=0` for 4 cycles → `pc_write=0`, `ifid_flush=1` each cycle.
  - `branch_taken=1` in the 3rd cycle → `pc_write=1`, `pc_sel=1`.
- With `PC_CTRL_PERF_EN` defined:
  - Stimulus: 2 load-use stalls and 1 branch, then `rst`.
  - Required: `stall_cycles=2`, `flush_count=1` before `rst`; both 0 after.
